// File: rtl/pixtx_pkg.sv
// pixtx_pkg: shared types and constants for the pixel-drain UART transmitter.
//   pixtx_state_e  : FSM states for the fetch controller and the serializer
//   TX_IDLE_LVL / START_LVL / DATA_BITS : UART 8N1 line constants
//   clks_per_bit() : clock cycles per UART bit (integer division)
package pixtx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } pixtx_state_e;

  localparam logic        TX_IDLE_LVL = 1'b1;
  localparam logic        START_LVL   = 1'b0;
  localparam int unsigned DATA_BITS   = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART serializer (start, 8 data bits LSB first, optional even
// parity, stop). Optional feature macro: PIXTX_PARITY_EN.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   i_load        : accept i_byte (honoured only while idle)
//   i_byte        : byte to serialize
//   o_tx          : serial line (registered), idles high
//   o_busy        : high while a frame is on the line
//   o_done        : one-cycle pulse on the last cycle of the stop bit
module uart_tx_core
  import pixtx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  pixtx_state_e  r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_bit_end;
`ifdef PIXTX_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= TX_IDLE_LVL;
`ifdef PIXTX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef PIXTX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // tx is registered, so each transition loads the level of the bit that
  // follows; r_shift[0] is always the data bit currently on the line.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
`ifdef PIXTX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (i_load) begin
          w_state_nxt = START;
          w_baud_nxt  = '0;
          w_shift_nxt = i_byte;
          w_tx_nxt    = START_LVL;
`ifdef PIXTX_PARITY_EN
          w_par_nxt   = ^i_byte;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef PIXTX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = TX_IDLE_LVL;
`endif
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_baud_nxt  = '0;
          w_tx_nxt    = TX_IDLE_LVL;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = TX_IDLE_LVL;
      end
    endcase
  end

  assign o_tx   = r_tx;
  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == STOP) && w_bit_end;

endmodule

// File: rtl/pixel_drain_uart_tx.sv
// pixel_drain_uart_tx: drains pixels from the output FIFO and sends them to
// the host over UART; counts sent pixels and flags frame completion.
// Optional feature macro: PIXTX_PARITY_EN (even parity bit, 11-bit frame).
// Ports:
//   clk, rstn     : clock, async active-low reset
//   enable        : allow fetching new bytes (byte in flight always completes)
//   frame_clr     : clear px_sent/frame_done, honoured only when idle
//   fifo_rd_data  : FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : one-cycle registered FIFO read strobe
//   tx            : UART line, idles high
//   tx_busy       : high whenever not idle
//   px_sent       : bytes fully transmitted (saturating)
//   frame_done    : sticky, set when px_sent reaches FRAME_PIX
module pixel_drain_uart_tx
  import pixtx_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter logic [31:0] FRAME_PIX = 32'd614_400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        frame_clr,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        tx_busy,
  output logic [31:0] px_sent,
  output logic        frame_done
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);

  if (CPB < 4) begin : g_bad_baud
    $error("pixel_drain_uart_tx: CLK_HZ/BAUD must be at least 4");
  end

  pixtx_state_e r_state, w_state_nxt;
  logic         r_rd_en;
  logic [31:0]  r_px_sent;
  logic         r_frame_done;
  logic         w_core_busy, w_core_done, w_load;
  logic         w_idle, w_clr, w_start;

  // This FSM only walks IDLE -> FETCH -> LOAD; START..STOP live in the
  // serializer, so "IDLE" for the whole block means both are idle.
  assign w_idle  = (r_state == IDLE) && !w_core_busy;
  assign w_clr   = w_idle && frame_clr;
  assign w_start = w_idle && enable && !fifo_empty && !r_frame_done;
  assign w_load  = (r_state == LOAD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start && !w_clr) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_rd_en      <= 1'b0;
      r_px_sent    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_en <= (r_state == IDLE) && (w_state_nxt == FETCH);
      if (w_clr) begin
        r_px_sent    <= '0;
        r_frame_done <= 1'b0;
      end else if (w_core_done) begin
        if (r_px_sent != '1) r_px_sent <= r_px_sent + 32'd1;
        if ((r_px_sent + 32'd1) == FRAME_PIX) r_frame_done <= 1'b1;
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CPB)
  ) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_byte (fifo_rd_data),
    .o_tx   (tx),
    .o_busy (w_core_busy),
    .o_done (w_core_done)
  );

  assign fifo_rd_en = r_rd_en;
  assign tx_busy    = !w_idle;
  assign px_sent    = r_px_sent;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_drain_uart_tx.sv
// tb_pixel_drain_uart_tx: self-checking bench for pixel_drain_uart_tx.
// Builds with or without PIXTX_PARITY_EN; 10 clocks per bit, FRAME_PIX=4.
module tb_pixel_drain_uart_tx;

  localparam int CPB   = 10;
  localparam int FRAME = 4;
`ifdef PIXTX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rstn, enable, frame_clr, fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en, tx, tx_busy, frame_done;
  logic [31:0] px_sent;

  pixel_drain_uart_tx #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .FRAME_PIX(32'd4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .frame_clr   (frame_clr),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .px_sent     (px_sent),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_px = 0;
  int prev_f = 0;
  logic [7:0] fifo_q[$];

  always @(posedge clk) cyc++;

  // FIFO model: data appears the cycle after the read strobe.
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet(input int n, input int qsize);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1) cnt++;
    end
    chk("quiet_activity", cnt, 0);
    chk("fifo_untouched", fifo_q.size(), qsize);
  endtask

  task automatic clr_frame();
    bit idle;
    idle = 0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!tx_busy) idle = 1;
    end
    chk("idle_before_clr", idle, 1);
    frame_clr = 1'b1;
    @(negedge clk);
    frame_clr = 1'b0;
    exp_px = 0;
    chk("clr_px_sent", px_sent, 0);
    chk("clr_frame_done", frame_done, 0);
  endtask

  // Expected line waveform is built from the UART frame rules: start 0,
  // data LSB first, optional parity, stop 1; one bit per CPB cycles.
  task automatic send_check(input logic [7:0] data, input logic par,
                            input bit chk_gap, input int drop_t);
    logic [10:0] bits;
    bit seen;
    int f, k;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (NB == 11) bits[9] = par;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1;
    end
    if (!seen) begin
      chk("rd_en_timeout", 0, 1);
      return;
    end
    f = cyc;
    if (chk_gap) chk("frame_period", f - prev_f, NB * CPB + 3);
    prev_f = f;
    for (int t = 1; t <= 2 + NB * CPB; t++) begin
      @(negedge clk);
      if (t == drop_t) enable = 1'b0;
      if (t == 1) begin
        chk("rd_en_single", fifo_rd_en, 0);
        chk("tx_pre_start", tx, 1);
      end else if (t == 2) begin
        chk("start_latency", tx, 0);
      end else if (t < 2 + NB * CPB && (t - 2) % CPB == 5) begin
        k = (t - 2) / CPB;
        chk($sformatf("bit%0d_of_%02h", k, data), tx, bits[k]);
      end
    end
    exp_px = exp_px + 1;
    chk("tx_after_stop", tx, 1);
    chk("px_sent", px_sent, exp_px);
    chk("frame_done", frame_done, (exp_px >= FRAME) ? 1 : 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [7:0] b0, b1;
    bit seen;
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h03, 1'b0};
    tbl[3] = '{8'hFF, 1'b0};
    tbl[4] = '{8'h80, 1'b1};
    tbl[5] = '{8'h3C, 1'b0};

    rstn = 1'b0; enable = 1'b1; frame_clr = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_px_sent", px_sent, 0);
    chk("rst_frame_done", frame_done, 0);
    rstn = 1'b1;
    quiet(200, 0);

    // Table vectors, one byte at a time.
    foreach (tbl[i]) begin
      if (exp_px == FRAME) clr_frame();
      fifo_q.push_back(tbl[i].data);
      send_check(tbl[i].data, tbl[i].par, 0, -1);
    end

    // Back-to-back bytes.
    clr_frame();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
    send_check(8'h01, 1'b1, 0, -1);
    send_check(8'h02, 1'b1, 1, -1);
    send_check(8'h03, 1'b0, 1, -1);

    // Frame limit: 6 queued, only 4 leave until frame_clr.
    clr_frame();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) begin
      b0 = 8'(8'h10 + i);
      send_check(b0, ^b0, i > 0, -1);
    end
    quiet(300, 2);
    clr_frame();
    for (int i = 4; i < 6; i++) begin
      b0 = 8'(8'h10 + i);
      send_check(b0, ^b0, i > 4, -1);
    end

    // enable drops in the middle of D3.
    clr_frame();
    fifo_q.push_back(8'hC6); fifo_q.push_back(8'h5A);
    send_check(8'hC6, ^8'hC6, 0, 2 + 4 * CPB + 5);
    quiet(300, 1);
    enable = 1'b1;
    send_check(8'h5A, ^8'h5A, 0, -1);

    // Async reset in the middle of a zero data bit.
    fifo_q.push_back(8'h00);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1;
    end
    chk("rst_mid_rd_en_seen", seen, 1);
    repeat (2 + 3 * CPB + 5) @(negedge clk);
    chk("rst_mid_tx_low", tx, 0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_px", px_sent, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_px = 0;
    quiet(150, 0);

    // Random byte pairs against the frame-rule model.
    for (int j = 0; j < 6; j++) begin
      if (exp_px >= FRAME) clr_frame();
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      fifo_q.push_back(b0); fifo_q.push_back(b1);
      send_check(b0, ^b0, 0, -1);
      send_check(b1, ^b1, 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
